// File: rtl/instr_sequencer.sv
// instr_sequencer: five-phase sequencer and retire unit for the counter-based
// RV64 core. It steps FETCH->DECODE->EXECUTE->MEMORY->WRITEBACK and presents
// the current phase on `vital`, which gates the rest of the datapath. It uses
// the registered ALU results to drive data memory and register writeback, and
// it advances the PC and retired-instruction count when an instruction retires.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   opcode/func3/rd    instruction fields; captured at DECODE
//   imm                sign-extended branch/jal offset in instruction units
//   rs2_data           store data; captured at DECODE
//   alu_out            ALU result (address, arithmetic, jalr target)
//   branch_sel         ALU branch verdict, 3'b111 = not taken
//   jal_output         ALU-computed PC+1 for jal
//   mem_rdata          load data, valid the cycle after mem_re
//   vital              phase code
//   ir_load            latch instruction at pc (FETCH)
//   pc                 current instruction-indexed PC
//   mem_re/mem_we      data memory strobes (MEMORY)
//   mem_addr/mem_wdata data memory address and write data
//   reg_we/reg_waddr/reg_wdata register file write port (WRITEBACK)
//   halted             sequencer parked in HALT
//   instret            retired instruction count
module instr_sequencer #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [4:0]  rd,
  input  logic [63:0] imm,
  input  logic [63:0] rs2_data,
  input  logic [63:0] alu_out,
  input  logic [2:0]  branch_sel,
  input  logic [63:0] jal_output,
  input  logic [63:0] mem_rdata,
  output logic [2:0]  vital,
  output logic        ir_load,
  output logic [63:0] pc,
  output logic        mem_re,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic [63:0] reg_wdata,
  output logic        halted,
  output logic [63:0] instret
);

  localparam int DATA_W = 64;

  localparam logic [6:0] OP_HALT   = 7'b0000000;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] NOT_TAKEN = 3'b111;

  typedef enum logic [2:0] {
    FETCH     = 3'b000,
    DECODE    = 3'b001,
    EXECUTE   = 3'b010,
    MEMORY    = 3'b011,
    WRITEBACK = 3'b100,
    HALT      = 3'b111
  } phase_t;

  phase_t              phase;
  logic [DATA_W-1:0]   pc_r;
  logic [DATA_W-1:0]   instret_r;

  // Instruction fields captured on the DECODE->EXECUTE edge
  logic [6:0]          opcode_p1;
  logic [2:0]          func3_p1;
  logic [4:0]          rd_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [DATA_W-1:0]   rs2_p1;

  logic is_load, is_store, is_jal, is_jalr, is_branch, is_alu, writes_rd;

  // Next PC at retire; all arithmetic wraps modulo 2^64.
  function automatic logic [DATA_W-1:0] next_pc(
    input logic [DATA_W-1:0]        cur,
    input logic signed [DATA_W-1:0] offs,
    input logic                     br, jal, jalr,
    input logic [2:0]               verdict,
    input logic [DATA_W-1:0]        target
  );
    logic [DATA_W-1:0] seq;
    logic [DATA_W-1:0] rel;
    seq = cur + DATA_W'(1);
    rel = cur + $unsigned(offs);
    if (jalr)                           return target;
    else if (jal)                       return rel;
    else if (br && verdict != NOT_TAKEN) return rel;
    else                                return seq;
  endfunction

  always_comb begin
    is_load   = (opcode_p1 == OP_LOAD)  && (func3_p1 == 3'b011);
    is_store  = (opcode_p1 == OP_STORE) && (func3_p1 == 3'b011);
    is_jal    = (opcode_p1 == OP_JAL);
    is_jalr   = (opcode_p1 == OP_JALR)  && (func3_p1 == 3'b000);
    is_branch = (opcode_p1 == OP_BRANCH);
    is_alu    = (opcode_p1 == OP_ITYPE) || (opcode_p1 == OP_RTYPE);
    writes_rd = (is_alu || is_load || is_jal || is_jalr) && (rd_p1 != 5'd0);
  end

  // Phase register, PC and retire counter (control, reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= FETCH;
      pc_r      <= RESET_PC;
      instret_r <= '0;
    end else begin
      case (phase)
        FETCH:     phase <= DECODE;
        DECODE:    phase <= (opcode == OP_HALT) ? HALT : EXECUTE;
        EXECUTE:   phase <= MEMORY;
        MEMORY:    phase <= WRITEBACK;
        WRITEBACK: begin
          phase     <= FETCH;
          pc_r      <= next_pc(pc_r, imm_p1, is_branch, is_jal, is_jalr,
                               branch_sel, alu_out);
          instret_r <= instret_r + DATA_W'(1);
        end
        HALT:      phase <= HALT;
        default:   phase <= FETCH;
      endcase
    end
  end

  // Field capture (data, not reset; every use is gated by the phase)
  always_ff @(posedge clk) begin
    if (phase == DECODE) begin
      opcode_p1 <= opcode;
      func3_p1  <= func3;
      rd_p1     <= rd;
      imm_p1    <= $signed(imm);
      rs2_p1    <= rs2_data;
    end
  end

  // Moore decode of phase and captured fields
  always_comb begin
    ir_load   = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    reg_we    = 1'b0;
    reg_waddr = '0;
    reg_wdata = '0;
    case (phase)
      FETCH: ir_load = 1'b1;
      MEMORY: begin
        if (is_load || is_store) mem_addr = alu_out;
        mem_re = is_load;
        if (is_store) begin
          mem_we    = 1'b1;
          mem_wdata = rs2_p1;
        end
      end
      WRITEBACK: begin
        if (writes_rd) begin
          reg_we    = 1'b1;
          reg_waddr = rd_p1;
          if (is_load)      reg_wdata = mem_rdata;
          else if (is_jal)  reg_wdata = jal_output;
          else if (is_jalr) reg_wdata = pc_r + DATA_W'(1);
          else              reg_wdata = alu_out;
        end
      end
      default: ;
    endcase
  end

  assign vital   = phase;
  assign halted  = (phase == HALT);
  assign pc      = pc_r;
  assign instret = instret_r;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
  localparam logic [63:0] RPC = 64'h40;
  localparam logic [6:0] LD = 7'h03, SD = 7'h23, ADDI = 7'h13, ADD = 7'h33,
                         JAL = 7'h6F, JALR = 7'h67, BR = 7'h63;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [4:0]  rd;
  logic [63:0] imm, rs2_data, alu_out, jal_output, mem_rdata;
  logic [2:0]  branch_sel;
  logic [2:0]  vital;
  logic        ir_load, mem_re, mem_we, reg_we, halted;
  logic [63:0] pc, mem_addr, mem_wdata, reg_wdata, instret;
  logic [4:0]  reg_waddr;

  int checks = 0;
  int errors = 0;
  logic [63:0] m_pc, m_instret;

  always #5 clk = ~clk;

  instr_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .rd(rd), .imm(imm),
    .rs2_data(rs2_data), .alu_out(alu_out), .branch_sel(branch_sel),
    .jal_output(jal_output), .mem_rdata(mem_rdata), .vital(vital),
    .ir_load(ir_load), .pc(pc), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .reg_we(reg_we),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .halted(halted),
    .instret(instret)
  );

  task automatic garbage();
    opcode     = 7'($urandom);
    func3      = 3'($urandom);
    rd         = 5'($urandom);
    imm        = {$urandom, $urandom};
    rs2_data   = {$urandom, $urandom};
    alu_out    = {$urandom, $urandom};
    branch_sel = 3'($urandom);
    jal_output = {$urandom, $urandom};
    mem_rdata  = {$urandom, $urandom};
  endtask

  // Runs one instruction (entered in FETCH just after a falling edge) and
  // checks every output of every phase against the architectural model.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [4:0] rdi, input logic [63:0] immv,
                           input logic [63:0] rs2v, input logic [63:0] alu,
                           input logic [2:0] bsel, input logic [63:0] jo,
                           input logic [63:0] rdat);
    bit ld, st, jl, jr, br, al, we;
    logic [63:0] exp_wd, exp_next;
    ld = (op == LD) && (f3 == 3);
    st = (op == SD) && (f3 == 3);
    jl = (op == JAL);
    jr = (op == JALR) && (f3 == 0);
    br = (op == BR);
    al = (op == ADDI) || (op == ADD);
    we = (al || ld || jl || jr) && (rdi != 0);
    exp_wd = ld ? rdat : jl ? jo : jr ? m_pc + 1 : alu;
    if (jr)                      exp_next = alu;
    else if (jl)                 exp_next = m_pc + immv;
    else if (br && bsel != 3'b111) exp_next = m_pc + immv;
    else                         exp_next = m_pc + 1;
    for (int c = 0; c < 5; c++) begin
      garbage();
      if (c == 1) begin
        opcode = op; func3 = f3; rd = rdi; imm = immv; rs2_data = rs2v;
      end
      if (c >= 3) begin alu_out = alu; branch_sel = bsel; jal_output = jo; end
      if (c == 4) mem_rdata = rdat;
      #1;
      checks++; if (vital !== 3'(c)) begin errors++; $display("FAIL vital op=%h c=%0d got %b want %b", op, c, vital, 3'(c)); end
      checks++; if (ir_load !== (c == 0)) begin errors++; $display("FAIL ir_load c=%0d got %b", c, ir_load); end
      checks++; if (mem_re !== (c == 3 && ld)) begin errors++; $display("FAIL mem_re op=%h c=%0d got %b", op, c, mem_re); end
      checks++; if (mem_we !== (c == 3 && st)) begin errors++; $display("FAIL mem_we op=%h c=%0d got %b", op, c, mem_we); end
      checks++; if (reg_we !== (c == 4 && we)) begin errors++; $display("FAIL reg_we op=%h rd=%0d c=%0d got %b", op, rdi, c, reg_we); end
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL pc c=%0d got %h want %h", c, pc, m_pc); end
      checks++; if (instret !== m_instret) begin errors++; $display("FAIL instret got %0d want %0d", instret, m_instret); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halted got %b want 0", halted); end
      if (c == 3 && (ld || st)) begin
        checks++; if (mem_addr !== alu) begin errors++; $display("FAIL mem_addr got %h want %h", mem_addr, alu); end
      end
      if (c == 3 && st) begin
        checks++; if (mem_wdata !== rs2v) begin errors++; $display("FAIL mem_wdata got %h want %h", mem_wdata, rs2v); end
      end
      if (c == 4 && we) begin
        checks++; if (reg_waddr !== rdi) begin errors++; $display("FAIL reg_waddr got %0d want %0d", reg_waddr, rdi); end
        checks++; if (reg_wdata !== exp_wd) begin errors++; $display("FAIL reg_wdata op=%h got %h want %h", op, reg_wdata, exp_wd); end
      end
      @(negedge clk);
    end
    m_pc = exp_next;
    m_instret = m_instret + 1;
  endtask

  task automatic goto_pc(input logic [63:0] target);
    run_instr(JALR, 3'd0, 5'd0, 64'd0, 64'd0, target, 3'd0, 64'd0, 64'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    garbage();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); garbage(); #1;
      checks++; if (vital !== 3'b000) begin errors++; $display("FAIL rst_vital got %b want 000", vital); end
      checks++; if (pc !== RPC) begin errors++; $display("FAIL rst_pc got %h want %h", pc, RPC); end
      checks++; if (instret !== 64'd0) begin errors++; $display("FAIL rst_instret got %0d want 0", instret); end
      checks++; if ({mem_re, mem_we, reg_we, halted} !== 4'b0) begin errors++; $display("FAIL rst_strobes got %b want 0000", {mem_re, mem_we, reg_we, halted}); end
      checks++; if (ir_load !== 1'b1) begin errors++; $display("FAIL rst_ir_load got %b want 1", ir_load); end
      checks++; if ({mem_addr, mem_wdata, reg_waddr, reg_wdata} !== '0) begin errors++; $display("FAIL rst_data got %h %h %h %h want 0", mem_addr, mem_wdata, reg_waddr, reg_wdata); end
    end
    rst = 1'b0;
    m_pc = RPC;
    m_instret = 0;
  endtask

  task automatic test_alu();
    goto_pc(64'd0);
    run_instr(ADDI, 3'd0, 5'd5, 64'd0, 64'd0, 64'h2A, 3'd0, 64'd0, 64'd0);
    checks++; if (pc !== 64'd1) begin errors++; $display("FAIL addi_pc got %h want 1", pc); end
    run_instr(ADDI, 3'd0, 5'd0, 64'd0, 64'd0, 64'h2A, 3'd0, 64'd0, 64'd0);
    run_instr(ADD, 3'd0, 5'd31, 64'd0, 64'd0, 64'h1234_5678_9ABC_DEF0, 3'd0, 64'd0, 64'd0);
  endtask

  task automatic test_branch();
    goto_pc(64'd10);
    run_instr(BR, 3'd0, 5'd3, 64'd4, 64'd0, 64'd0, 3'b000, 64'd0, 64'd0);
    checks++; if (pc !== 64'd14) begin errors++; $display("FAIL beq_taken_pc got %0d want 14", pc); end
    goto_pc(64'd10);
    run_instr(BR, 3'd0, 5'd3, 64'd4, 64'd0, 64'd0, 3'b111, 64'd0, 64'd0);
    checks++; if (pc !== 64'd11) begin errors++; $display("FAIL beq_nt_pc got %0d want 11", pc); end
  endtask

  task automatic test_jumps();
    goto_pc(64'd3);
    run_instr(JAL, 3'd0, 5'd1, -64'sd2, 64'd0, 64'd0, 3'd0, 64'd4, 64'd0);
    checks++; if (pc !== 64'd1) begin errors++; $display("FAIL jal_pc got %0d want 1", pc); end
    goto_pc(64'd7);
    run_instr(JALR, 3'd0, 5'd2, 64'd0, 64'd0, 64'h20, 3'd0, 64'd0, 64'd0);
    checks++; if (pc !== 64'h20) begin errors++; $display("FAIL jalr_pc got %h want 20", pc); end
  endtask

  task automatic test_mem();
    run_instr(LD, 3'd3, 5'd9, 64'd0, 64'd0, 64'h100, 3'd0, 64'd0, 64'hDEAD);
    run_instr(SD, 3'd3, 5'd9, 64'd0, 64'hCAFE_F00D_0000_0001, 64'h208, 3'd0, 64'd0, 64'd0);
    run_instr(LD, 3'd2, 5'd9, 64'd0, 64'd0, 64'h100, 3'd0, 64'd0, 64'hDEAD);
  endtask

  task automatic test_wrap_unknown();
    goto_pc(64'hFFFF_FFFF_FFFF_FFFF);
    run_instr(ADDI, 3'd0, 5'd4, 64'd0, 64'd0, 64'd7, 3'd0, 64'd0, 64'd0);
    checks++; if (pc !== 64'd0) begin errors++; $display("FAIL wrap_pc got %h want 0", pc); end
    run_instr(BR, 3'd1, 5'd0, -64'sd1, 64'd0, 64'd0, 3'b001, 64'd0, 64'd0);
    run_instr(7'h7F, 3'd0, 5'd6, 64'd9, 64'd0, 64'd9, 3'd0, 64'd9, 64'd9);
    run_instr(7'h0F, 3'd3, 5'd6, 64'd9, 64'd0, 64'd9, 3'd0, 64'd9, 64'd9);
  endtask

  task automatic test_random();
    logic [6:0] ops [7] = '{ADDI, ADD, LD, SD, JAL, JALR, BR};
    logic [6:0] op;
    logic [2:0] f3;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 7) begin
        do op = 7'($urandom); while (op == 0 || op == ADDI || op == ADD || op == LD ||
                                     op == SD || op == JAL || op == JALR || op == BR);
      end else op = ops[$urandom_range(0, 6)];
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
           (op == LD || op == SD) ? 3'd3 : 3'd0;
      run_instr(op, f3, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, 3'($urandom), {$urandom, $urandom},
                {$urandom, $urandom});
    end
  endtask

  task automatic test_reset_mid();
    goto_pc(64'h77);
    garbage(); #1;
    @(negedge clk); garbage(); opcode = JAL; func3 = 0; rd = 5'd1; imm = 64'd5; #1;
    @(negedge clk); garbage(); rst = 1'b1; #1;
    checks++; if (vital !== 3'b010) begin errors++; $display("FAIL mid_exec_vital got %b want 010", vital); end
    @(negedge clk); garbage(); #1;
    checks++; if (vital !== 3'b000) begin errors++; $display("FAIL mid_rst_vital got %b want 000", vital); end
    checks++; if (pc !== RPC) begin errors++; $display("FAIL mid_rst_pc got %h want %h", pc, RPC); end
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL mid_rst_instret got %0d want 0", instret); end
    checks++; if ({reg_we, mem_re, mem_we} !== 3'b0) begin errors++; $display("FAIL mid_rst_strobes got %b want 000", {reg_we, mem_re, mem_we}); end
    rst = 1'b0;
    m_pc = RPC;
    m_instret = 0;
    run_instr(ADDI, 3'd0, 5'd8, 64'd0, 64'd0, 64'h55, 3'd0, 64'd0, 64'd0);
  endtask

  task automatic test_halt();
    garbage(); #1;
    @(negedge clk); garbage(); opcode = 7'd0; #1;
    checks++; if (vital !== 3'b001) begin errors++; $display("FAIL halt_decode_vital got %b want 001", vital); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); garbage(); #1;
      checks++; if (vital !== 3'b111 || halted !== 1'b1) begin errors++; $display("FAIL halt_state got vital=%b halted=%b want 111/1", vital, halted); end
      checks++; if (pc !== m_pc || instret !== m_instret) begin errors++; $display("FAIL halt_frozen got pc=%h instret=%0d want %h/%0d", pc, instret, m_pc, m_instret); end
      checks++; if ({ir_load, mem_re, mem_we, reg_we} !== 4'b0) begin errors++; $display("FAIL halt_strobes got %b want 0000", {ir_load, mem_re, mem_we, reg_we}); end
    end
    rst = 1'b1;
    @(negedge clk); garbage(); #1;
    checks++; if (vital !== 3'b000 || halted !== 1'b0 || pc !== RPC) begin errors++; $display("FAIL halt_exit got vital=%b halted=%b pc=%h", vital, halted, pc); end
    rst = 1'b0;
    m_pc = RPC;
    m_instret = 0;
    run_instr(ADDI, 3'd0, 5'd2, 64'd0, 64'd0, 64'h9, 3'd0, 64'd0, 64'd0);
  endtask

  initial begin
    test_reset();
    run_instr(ADDI, 3'd0, 5'd1, 64'd0, 64'd0, 64'h3, 3'd0, 64'd0, 64'd0);
    test_alu();
    test_branch();
    test_jumps();
    test_mem();
    test_wrap_unknown();
    test_random();
    test_reset_mid();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle phase sequencer and retire unit for the counter-based RV64 core. It drives the 3-bit phase code `vital` that gates every datapath block, including ALU execute at phase `3'b010`. It consumes the ALU results (`alu_out`, `branch_sel`, `jal_output`) to perform memory access and register writeback, and it updates the PC. The block sits between the ALU outputs and the register file, data memory and instruction register.

## Interface
- `RESET_PC`, default 64'd0, PC value loaded on reset (PC is instruction-indexed, +1 per instruction).
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 7: opcode from the instruction register.
- `func3` input 3: funct3 from the instruction register.
- `rd` input 5: destination register index.
- `imm` input 64: sign-extended branch/jal offset, in instruction units.
- `rs2_data` input 64: store data.
- `alu_out` input 64: ALU result (add/logic/shift/address/jalr target).
- `branch_sel` input 3: ALU branch verdict; `3'b111` = not taken, any other value = taken.
- `jal_output` input 64: ALU-computed PC+1 for jal.
- `mem_rdata` input 64: data memory read data, valid the cycle after `mem_re`.
- `vital` output 3: current phase code.
- `ir_load` output 1: latch the instruction at `pc` into the instruction register.
- `pc` output 64: current PC.
- `mem_re` output 1: data memory read strobe.
- `mem_we` output 1: data memory write strobe.
- `mem_addr` output 64: data memory address.
- `mem_wdata` output 64: data memory write data.
- `reg_we` output 1: register file write enable.
- `reg_waddr` output 5: register file write address.
- `reg_wdata` output 64: register file write data.
- `halted` output 1: the sequencer has stopped.
- `instret` output 64: count of retired instructions.

## Operation
- Phases and their `vital` codes: FETCH 000, DECODE 001, EXECUTE 010, MEMORY 011, WRITEBACK 100, HALT 111.
- Normal sequence is FETCH→DECODE→EXECUTE→MEMORY→WRITEBACK→FETCH. Every instruction takes 5 cycles, including NOPs and unknown opcodes.
- `opcode`, `func3`, `rd`, `imm` and `rs2_data` are captured on the DECODE→EXECUTE edge. All later decisions for that instruction use only the captured copies.
- FETCH: `ir_load`=1.
- MEMORY, load (opcode 0000011, func3 011): `mem_re`=1 and `mem_addr`=`alu_out`.
- MEMORY, store (opcode 0100011, func3 011): `mem_we`=1, `mem_addr`=`alu_out`, `mem_wdata`=captured `rs2_data`.
- WRITEBACK writes the register file; `reg_we` is suppressed when rd=0:
  - I-type (0010011) and R-type (0110011): `reg_wdata`=`alu_out`.
  - Load: `reg_wdata`=`mem_rdata`.
  - jal (1101111): `reg_wdata`=`jal_output`.
  - jalr (1100111, func3 000): `reg_wdata`=`pc`+1.
- PC update on the WRITEBACK→FETCH edge:
  - Branch (1100011): `pc`+`imm` if `branch_sel`≠111, otherwise `pc`+1.
  - jal: `pc`+`imm`.
  - jalr: `alu_out`.
  - All other opcodes: `pc`+1.
- `instret` increments by 1 on the same edge.
- Opcode 0000000 captured at DECODE: go to HALT on the next edge instead of EXECUTE.
  - No strobes are issued and `pc` and `instret` are frozen.
  - `halted`=1.
  - HALT is left only through `rst`.
- Unknown opcodes retire as NOPs: no strobes, `pc`+1.
- PC arithmetic is 64-bit modulo 2^64, so wrap-around is silent (`pc`=2^64−1 +1 → 0).
- Outputs are Moore-decoded from the phase register and captured fields. Strobes are high for exactly the one cycle of their phase.

## Timing
- Reset state: `vital`=000, `pc`=`RESET_PC`, `instret`=0, `halted`=0.
- In reset, every strobe (`ir_load` excepted) is 0. `mem_addr`, `mem_wdata`, `reg_waddr` and `reg_wdata` are 0.
- `ir_load`=1 in the first cycle after reset, because the phase is FETCH.
- `rst` high in any phase, including mid-instruction or HALT: the next edge forces FETCH with the reset values. No partial writeback or PC update may occur.
- The ALU registers its result at the end of EXECUTE. The sequencer reads `alu_out`/`branch_sel`/`jal_output` only in MEMORY and WRITEBACK.
- Load latency: `mem_re` in cycle N, and `mem_rdata` is sampled and written in cycle N+1.
- Throughput: 1 instruction per 5 clocks. Instruction k retires at cycle 5k after reset release.

## Test plan
- Reset: hold `rst` for 3 cycles with `RESET_PC`=0x40 → `vital`=000, `pc`=0x40, `instret`=0, all write strobes 0; release → phases go 000,001,010,011,100,000.
- addi rd=5 with `alu_out`=0x2A → `reg_we`=1 only in cycle 5, `reg_waddr`=5, `reg_wdata`=0x2A; `pc` 0→1; `instret`=1. The same test with rd=0 → no `reg_we`.
- beq at `pc`=10 with `imm`=4: `branch_sel`=000 → `pc`=14; `branch_sel`=111 → `pc`=11. In both cases `reg_we` stays 0.
- jal rd=1 at `pc`=3 with `imm`=−2 and `jal_output`=4 → `reg_wdata`=4, `pc`=1. jalr rd=2 at `pc`=7 with `alu_out`=0x20 → `reg_wdata`=8, `pc`=0x20.
- ld with `alu_out`=0x100 → `mem_re`=1 and `mem_addr`=0x100 in MEMORY; `mem_rdata`=0xDEAD in WRITEBACK → written to rd. sd → `mem_we`=1 with `mem_wdata`=`rs2_data`, and no `reg_we`.
- Opcode 0 → `vital`=111 and `halted`=1, with `pc` and `instret` frozen for 20 cycles. Separately, assert `rst` during EXECUTE of a jal → next cycle is FETCH, `pc`=`RESET_PC`, and no register write occurs.
